ps2_mouse_cursor: RTL and testbench
===================================

Name: ps2_mouse_cursor

Overview:
Downstream stage of the PS/2 mouse path. Consumes decoded mouse packets: 8-bit magnitude, sign, overflow per axis, plus left-button state. Accumulates them into an absolute on-screen cursor position clamped to the display window. Produces a registered cursor position and left-click edge pulses for the VGA overlay and the CPU MMIO peripheral.

Parameters:
H_RES, 640, horizontal pixel count; cursor_x range is 0..H_RES-1
V_RES, 480, vertical pixel count; cursor_y range is 0..V_RES-1
POS_W, 11, width of the cursor coordinate outputs
SPEED_SHIFT, 0, delta is multiplied by 2^SPEED_SHIFT before accumulation (0..3)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
pkt_valid  in  1  packet fields valid this cycle
pkt_ready  out  1  block can accept a packet
x_mag  in  8  X movement magnitude byte (two's-complement low bits)
y_mag  in  8  Y movement magnitude byte
x_symbol  in  1  X sign (1 = negative)
y_symbol  in  1  Y sign (1 = negative, PS/2 up = positive)
x_overflow  in  1  X overflow flag
y_overflow  in  1  Y overflow flag
lbm_in  in  1  left button state from packet
cursor_x  out  POS_W  current cursor X
cursor_y  out  POS_W  current cursor Y (0 = top row)
lbm  out  1  registered left button state
click  out  1  one-cycle pulse on left-button press
pos_valid  out  1  one-cycle pulse when cursor_x/cursor_y update

Behaviour:
- Reset (async, any state): cursor_x=H_RES/2, cursor_y=V_RES/2, lbm=0, click=0, pos_valid=0, pkt_ready=1, FSM=IDLE. Any pending packet is discarded.
- FSM states: IDLE, CALC_X, CALC_Y, COMMIT.
- IDLE: pkt_ready=1. When pkt_valid=1, the packet is accepted. All fields are latched and the FSM goes to CALC_X.
- CALC_X, CALC_Y, COMMIT: pkt_ready=0. pkt_valid is ignored and packets are not queued.
- Delta formation: dX = signed 9-bit {x_symbol, x_mag}.
  - If x_overflow=1, dX saturates: +255 if x_symbol=0, -256 if x_symbol=1.
  - Y uses the same rule.
  - Delta is then arithmetically shifted left by SPEED_SHIFT in a 13-bit signed intermediate.
- CALC_X: new_x = cursor_x + dX in 13-bit signed. Clamp to 0 if the result is < 0, and to H_RES-1 if it is > H_RES-1. Result goes to a shadow register. Next state: CALC_Y.
- CALC_Y: new_y = cursor_y - dY, because screen Y grows downward. Clamp to 0..V_RES-1 into a shadow register. Next state: COMMIT.
- COMMIT: cursor_x and cursor_y load from the shadows in the same cycle, so they are never torn.
  - pos_valid=1 for exactly this cycle, even if the position is unchanged.
  - lbm <= latched lbm_in.
  - click=1 for this cycle iff latched lbm_in=1 and the previous lbm=0.
  - Next state: IDLE.
- Latency: packet accepted in cycle N; new position and pos_valid are visible at cycle N+3; pkt_ready returns high at N+3.
- Throughput: one packet per 4 cycles. Upstream must hold pkt_valid until it sees pkt_ready.
- Boundaries:
  - Clamping saturates and never wraps.
  - A zero delta still produces a pos_valid pulse.
  - Holding the button down across packets produces no further click pulses.
  - A button release produces no pulse.

Optional Feature:
Macro PS2_CURSOR_ACCEL_EN.
- Defined: after the SPEED_SHIFT step, any axis delta with |d| >= 16 is doubled before clamping. This is a simple acceleration curve; the doubling is independent per axis and happens inside the 13-bit intermediate.
- Undefined: no acceleration logic is synthesized, and deltas are used exactly as formed above.

Test Plan:
- Release rst -> cursor (320,240), pkt_ready=1, lbm=0, click=0, pos_valid=0.
- Packet x_mag=0x0A, x_symbol=0, y_mag=0x05, y_symbol=0 -> at N+3 cursor=(330,235), one pos_valid pulse, pkt_ready low for 3 cycles.
- Forty packets with x_mag=0xF6, x_symbol=1 (-10) from x=320 -> x reaches 0 and stays 0 with no wrap; y unchanged at 240.
- Packet x_overflow=1, x_symbol=0 from x=320 -> x=575. Repeat -> x=639 (clamped). y_overflow=1, y_symbol=0 from y=240 -> y=0.
- Packet sequence lbm_in = 0,1,1,0,1 -> exactly two click pulses, on the 2nd and 5th commits. lbm follows lbm_in per commit.
- Assert rst during CALC_Y of a dx=+50 packet -> cursor returns to (320,240), no pos_valid, pkt_ready=1 after release. pkt_valid pulsed during busy states is dropped, with no position change.

Source files
------------

// File: rtl/ps2_mouse_cursor_if.sv
// Decoded PS/2 mouse packet handshake between the packet decoder and the cursor stage.
interface ps2_mouse_cursor_if;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [7:0] x_mag;
  logic [7:0] y_mag;
  logic       x_symbol;
  logic       y_symbol;
  logic       x_overflow;
  logic       y_overflow;
  logic       lbm_in;

  modport master (
    output pkt_valid, x_mag, y_mag, x_symbol, y_symbol, x_overflow, y_overflow, lbm_in,
    input  pkt_ready
  );

  modport slave (
    input  pkt_valid, x_mag, y_mag, x_symbol, y_symbol, x_overflow, y_overflow, lbm_in,
    output pkt_ready
  );
endinterface

// File: rtl/ps2_mouse_cursor.sv
// Accumulates decoded PS/2 mouse packets into a clamped absolute cursor plus left-click pulses.
// Optional acceleration (|delta| >= 16 doubled per axis) is enabled by defining PS2_CURSOR_ACCEL_EN.
module ps2_mouse_cursor #(
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int POS_W       = 11,
  parameter int SPEED_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  ps2_mouse_cursor_if.slave    pkt,
  output logic [POS_W-1:0]     cursor_x,
  output logic [POS_W-1:0]     cursor_y,
  output logic                 lbm,
  output logic                 click,
  output logic                 pos_valid
);

  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;

  state_t state_q, state_d;

  logic             accept, calc_x_en, calc_y_en, commit_en;
  logic [7:0]       x_mag_q, y_mag_q;
  logic             x_sym_q, y_sym_q, x_ovf_q, y_ovf_q, lbm_in_q;
  logic [POS_W-1:0] cursor_x_q, cursor_y_q, shadow_x_q, shadow_y_q;
  logic [POS_W-1:0] shadow_x_d, shadow_y_d;
  logic             lbm_q, click_q, pos_valid_q;
  logic signed [12:0] dx, dy;
  logic signed [13:0] sum_x, sum_y;

  // Signed 9-bit delta, saturated on overflow, scaled inside a 13-bit intermediate.
  function automatic logic signed [12:0] form_delta(input logic [7:0] mag, input logic sgn,
                                                    input logic ovf);
    logic signed [8:0]  d9;
    logic signed [12:0] d13;
    if (ovf) d9 = sgn ? -9'sd256 : 9'sd255;
    else     d9 = $signed({sgn, mag});
    d13 = {{4{d9[8]}}, d9};
    d13 = d13 <<< SPEED_SHIFT;
`ifdef PS2_CURSOR_ACCEL_EN
    if (d13 >= 13'sd16 || d13 <= -13'sd16) d13 = d13 <<< 1;
`else
`endif
    return d13;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pkt.pkt_valid) state_d = CALC_X;
      CALC_X:  state_d = CALC_Y;
      CALC_Y:  state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pkt.pkt_ready = (state_q == IDLE);
    accept        = (state_q == IDLE) && pkt.pkt_valid;
    calc_x_en     = (state_q == CALC_X);
    calc_y_en     = (state_q == CALC_Y);
    commit_en     = (state_q == COMMIT);
  end

  assign dx = form_delta(x_mag_q, x_sym_q, x_ovf_q);
  assign dy = form_delta(y_mag_q, y_sym_q, y_ovf_q);

  // One extra bit over the delta width so large scaled deltas clamp instead of wrapping.
  assign sum_x = $signed({{(14-POS_W){1'b0}}, cursor_x_q}) + $signed({dx[12], dx});
  assign sum_y = $signed({{(14-POS_W){1'b0}}, cursor_y_q}) - $signed({dy[12], dy});

  always_comb begin
    if (sum_x < 14'sd0)          shadow_x_d = '0;
    else if (sum_x > (H_RES-1))  shadow_x_d = POS_W'(H_RES-1);
    else                         shadow_x_d = POS_W'(sum_x);
    if (sum_y < 14'sd0)          shadow_y_d = '0;
    else if (sum_y > (V_RES-1))  shadow_y_d = POS_W'(V_RES-1);
    else                         shadow_y_d = POS_W'(sum_y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_mag_q     <= '0;
      y_mag_q     <= '0;
      x_sym_q     <= 1'b0;
      y_sym_q     <= 1'b0;
      x_ovf_q     <= 1'b0;
      y_ovf_q     <= 1'b0;
      lbm_in_q    <= 1'b0;
      shadow_x_q  <= POS_W'(H_RES/2);
      shadow_y_q  <= POS_W'(V_RES/2);
      cursor_x_q  <= POS_W'(H_RES/2);
      cursor_y_q  <= POS_W'(V_RES/2);
      lbm_q       <= 1'b0;
      click_q     <= 1'b0;
      pos_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        x_mag_q  <= pkt.x_mag;
        y_mag_q  <= pkt.y_mag;
        x_sym_q  <= pkt.x_symbol;
        y_sym_q  <= pkt.y_symbol;
        x_ovf_q  <= pkt.x_overflow;
        y_ovf_q  <= pkt.y_overflow;
        lbm_in_q <= pkt.lbm_in;
      end
      if (calc_x_en) shadow_x_q <= shadow_x_d;
      if (calc_y_en) shadow_y_q <= shadow_y_d;
      // Both axes load together so consumers never see a half-updated position.
      if (commit_en) begin
        cursor_x_q <= shadow_x_q;
        cursor_y_q <= shadow_y_q;
        lbm_q      <= lbm_in_q;
      end
      pos_valid_q <= commit_en;
      click_q     <= commit_en && lbm_in_q && !lbm_q;
    end
  end

  assign cursor_x  = cursor_x_q;
  assign cursor_y  = cursor_y_q;
  assign lbm       = lbm_q;
  assign click     = click_q;
  assign pos_valid = pos_valid_q;

endmodule

// File: tb/tb_ps2_mouse_cursor.sv
// Directed bench for ps2_mouse_cursor: a packet-level reference model checked every cycle,
// plus literal expectations for the headline scenarios.
module tb_ps2_mouse_cursor;
  localparam int H_RES = 640;
  localparam int V_RES = 480;
  localparam int POS_W = 11;
  localparam int SPEED_SHIFT = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [POS_W-1:0] cursor_x, cursor_y;
  logic lbm, click, pos_valid;

  ps2_mouse_cursor_if pif();

  ps2_mouse_cursor #(.H_RES(H_RES), .V_RES(V_RES), .POS_W(POS_W), .SPEED_SHIFT(SPEED_SHIFT)) dut (
    .clk(clk), .rst(rst), .pkt(pif),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .lbm(lbm), .click(click), .pos_valid(pos_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet taken while idle takes effect three clocks later.
  int mx, my, busy, pdx, pdy;
  bit mlbm, mclick, mpv, plbm;

  function automatic int delta(input int mag, input bit s, input bit o);
    int d;
    if (o) d = s ? -256 : 255;
    else   d = s ? mag - 256 : mag;
    d = d * (2 ** SPEED_SHIFT);
`ifdef PS2_CURSOR_ACCEL_EN
    if (d >= 16 || d <= -16) d = d * 2;
`endif
    return d;
  endfunction

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      mx = H_RES / 2; my = V_RES / 2; mlbm = 0; mclick = 0; mpv = 0; busy = 0;
    end else begin
      mpv = 0; mclick = 0;
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          mx = clampi(mx + pdx, H_RES - 1);
          my = clampi(my - pdy, V_RES - 1);
          mclick = plbm && !mlbm;
          mlbm = plbm;
          mpv = 1;
        end
      end else if (pif.pkt_valid) begin
        pdx = delta(int'(pif.x_mag), pif.x_symbol, pif.x_overflow);
        pdy = delta(int'(pif.y_mag), pif.y_symbol, pif.y_overflow);
        plbm = pif.lbm_in;
        busy = 3;
      end
    end
  end

  int commit_idx = 0;
  logic [7:0] click_mask = '0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("pkt_ready", int'(pif.pkt_ready), int'(busy == 0));
      chk("cursor_x", int'(cursor_x), mx);
      chk("cursor_y", int'(cursor_y), my);
      chk("lbm", int'(lbm), int'(mlbm));
      chk("click", int'(click), int'(mclick));
      chk("pos_valid", int'(pos_valid), int'(mpv));
      if (pos_valid) begin
        if (click && commit_idx < 8) click_mask[commit_idx] = 1'b1;
        commit_idx++;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); @(negedge clk); #1 rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] xm, input logic xs, input logic xo,
                      input logic [7:0] ym, input logic ys, input logic yo, input logic lb);
    int t = 0;
    @(negedge clk);
    while (!pif.pkt_ready && t < 20) begin @(negedge clk); t++; end
    chk("ready_wait_bound", int'(t < 20), 1);
    #1;
    pif.x_mag = xm; pif.x_symbol = xs; pif.x_overflow = xo;
    pif.y_mag = ym; pif.y_symbol = ys; pif.y_overflow = yo;
    pif.lbm_in = lb; pif.pkt_valid = 1'b1;
    @(negedge clk); #1 pif.pkt_valid = 1'b0;
  endtask

  task automatic settle();
    int t = 0;
    while (!pif.pkt_ready && t < 20) begin @(negedge clk); t++; end
    chk("settle_bound", int'(t < 20), 1);
    @(negedge clk);
  endtask

  initial begin
    int lo, pv_seen;
    pif.pkt_valid = 0; pif.x_mag = 0; pif.y_mag = 0; pif.x_symbol = 0; pif.y_symbol = 0;
    pif.x_overflow = 0; pif.y_overflow = 0; pif.lbm_in = 0;
    #3 rst = 1'b1;
    #1 chk_en = 1'b1;
    @(negedge clk); @(negedge clk); #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_x", int'(cursor_x), 320);
    chk("reset_y", int'(cursor_y), 240);
    chk("reset_ready", int'(pif.pkt_ready), 1);
    chk("reset_lbm", int'(lbm), 0);
    chk("reset_click", int'(click), 0);
    chk("reset_pos_valid", int'(pos_valid), 0);

    // +10 right, +5 up: screen y decreases
    send(8'h0A, 0, 0, 8'h05, 0, 0, 0);
    lo = 0;
    while (!pif.pkt_ready && lo < 10) begin lo++; @(negedge clk); end
    chk("busy_cycles", lo, 3);
    chk("basic_pos_valid", int'(pos_valid), 1);
    chk("basic_x", int'(cursor_x), 330);
    chk("basic_y", int'(cursor_y), 235);
    @(negedge clk);

    do_reset();
    for (int i = 0; i < 40; i++) send(8'hF6, 1, 0, 8'h00, 0, 0, 0);
    settle();
    chk("left_clamp_x", int'(cursor_x), 0);
    chk("left_clamp_y", int'(cursor_y), 240);

    do_reset();
    send(8'h00, 0, 1, 8'h00, 0, 0, 0); settle();
    chk("ovf_x_first", int'(cursor_x), 575);
    send(8'h00, 0, 1, 8'h00, 0, 0, 0); settle();
    chk("ovf_x_clamp", int'(cursor_x), 639);
    send(8'h00, 0, 0, 8'h00, 0, 1, 0); settle();
    chk("ovf_y_top", int'(cursor_y), 0);
    send(8'h00, 1, 1, 8'h00, 1, 1, 0); settle();
    chk("neg_ovf_x", int'(cursor_x), 383);
    chk("neg_ovf_y", int'(cursor_y), 256);

    do_reset();
    commit_idx = 0; click_mask = '0;
    send(8'h00, 0, 0, 8'h00, 0, 0, 0);
    send(8'h00, 0, 0, 8'h00, 0, 0, 1);
    send(8'h00, 0, 0, 8'h00, 0, 0, 1);
    send(8'h00, 0, 0, 8'h00, 0, 0, 0);
    send(8'h00, 0, 0, 8'h00, 0, 0, 1);
    settle();
    chk("commit_count", commit_idx, 5);
    chk("click_commits", int'(click_mask), 8'b0001_0010);
    chk("final_lbm", int'(lbm), 1);
    chk("zero_delta_x", int'(cursor_x), 320);

    do_reset();
    send(8'd50, 0, 0, 8'h00, 0, 0, 0);
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    pv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (pos_valid) pv_seen++;
    end
    chk("abort_no_pos_valid", pv_seen, 0);
    chk("abort_x", int'(cursor_x), 320);
    chk("abort_y", int'(cursor_y), 240);
    chk("abort_ready", int'(pif.pkt_ready), 1);

    // A second packet offered while busy must be dropped.
    send(8'd1, 0, 0, 8'h00, 0, 0, 0);
    pif.x_mag = 8'd100; pif.pkt_valid = 1'b1;
    @(negedge clk); #1 pif.pkt_valid = 1'b0;
    settle();
    repeat (4) @(negedge clk);
    chk("drop_busy_x", int'(cursor_x), 321);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
